// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input and
// an autonomous scan mode that walks one active bit with a dwell time.
module decoder_onehot_seq #(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               in_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_inc;

    assign in_ready = en & ~mode & rst_n;
    assign sel_inc  = sel_q + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        out_d   = out_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            out_d   = '0;
            valid_d = 1'b0;
            sel_d   = '0;
            cnt_d   = '0;
        end else if (!mode) begin
            state_d = DEC;
            cnt_d   = '0;
            if (in_valid) begin
                out_d   = OUT_W'(1) << in_sel;
                sel_d   = in_sel;
                valid_d = 1'b1;
            end
        end else begin
            state_d = SCAN;
            valid_d = 1'b1;
            if (state_q != SCAN) begin
                // Entry load to index 0 never pulses wrap
                out_d = OUT_W'(1);
                sel_d = '0;
                cnt_d = dwell;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else begin
                sel_d  = sel_inc;
                out_d  = OUT_W'(1) << sel_inc;
                cnt_d  = dwell;
                wrap_d = (sel_inc == '0);
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign cur_sel   = sel_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed and randomized checks of decoder_onehot_seq (SEL_W=3)
// against a cycle-level behavioural reference model.
module tb_decoder_onehot_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [2:0] in_sel;
    logic       in_ready;
    logic [7:0] dwell;
    logic [7:0] out;
    logic       out_valid;
    logic [2:0] cur_sel;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    // reference model: position index, cycles left at this position
    int m_st, m_pos, m_left;
    bit m_valid, m_wrap;

    always #5 clk = ~clk;

    decoder_onehot_seq #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
        .dwell(dwell), .out(out), .out_valid(out_valid),
        .cur_sel(cur_sel), .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_out,
                           input logic e_v, input logic [2:0] e_sel,
                           input logic e_wrap);
        chk({tag, ".out"}, out, e_out);
        chk({tag, ".valid"}, out_valid, e_v);
        chk({tag, ".cur_sel"}, cur_sel, e_sel);
        chk({tag, ".wrap"}, wrap, e_wrap);
    endtask

    task automatic model_step();
        if (!en) begin
            m_st = 0; m_pos = 0; m_valid = 0; m_wrap = 0;
        end else if (!mode) begin
            m_st = 1; m_wrap = 0;
            if (in_valid) begin
                m_pos = in_sel; m_valid = 1;
            end
        end else if (m_st != 2) begin
            m_st = 2; m_pos = 0; m_valid = 1; m_wrap = 0;
            m_left = dwell + 1;
        end else begin
            m_left--; m_wrap = 0;
            if (m_left == 0) begin
                m_pos = (m_pos + 1) % 8;
                m_left = dwell + 1;
                m_wrap = (m_pos == 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_sel = '0; dwell = '0;
        #2;
        chk_out("reset", 8'h00, 0, 3'd0, 0);
        chk("reset.in_ready", in_ready, 1'b0);
        #10 rst_n = 1'b1;

        // decode single transfer
        en = 1; mode = 0; in_valid = 1; in_sel = 3'd5;
        #1 chk("dec.in_ready", in_ready, 1'b1);
        tick();
        chk_out("dec5", 8'h20, 1, 3'd5, 0);
        in_valid = 0;
        tick();
        chk_out("dec5.hold", 8'h20, 1, 3'd5, 0);

        // back-to-back decode
        in_valid = 1; in_sel = 3'd0; tick();
        chk_out("b2b0", 8'h01, 1, 3'd0, 0);
        in_sel = 3'd7; tick();
        chk_out("b2b7", 8'h80, 1, 3'd7, 0);
        in_sel = 3'd3; tick();
        chk_out("b2b3", 8'h08, 1, 3'd3, 0);
        in_valid = 0; in_sel = 3'd2; tick();
        chk_out("b2b.noxfer", 8'h08, 1, 3'd3, 0);

        // scan, dwell 0
        mode = 1; dwell = 8'd0;
        #1 chk("scan0.in_ready", in_ready, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out($sformatf("scan0[%0d]", i), 8'(1 << (i % 8)), 1,
                    3'(i % 8), i == 8);
            chk("scan0.in_ready", in_ready, 1'b0);
        end

        // scan, dwell 2 then 0 mid-position
        en = 0; tick();
        chk_out("idle", 8'h00, 0, 3'd0, 0);
        en = 1; mode = 1; dwell = 8'd2;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_out($sformatf("scan2[%0d]", i), 8'(1 << (i / 3)), 1,
                    3'(i / 3), 0);
        end
        dwell = 8'd0;
        tick(); chk_out("scan2.d0a", 8'h04, 1, 3'd2, 0);
        tick(); chk_out("scan2.d0b", 8'h04, 1, 3'd2, 0);
        tick(); chk_out("scan2.d0c", 8'h08, 1, 3'd3, 0);
        tick(); chk_out("scan2.d0d", 8'h10, 1, 3'd4, 0);

        // mode / enable switching
        mode = 0; in_valid = 0;
        tick(); chk_out("sw.hold", 8'h10, 1, 3'd4, 0);
        tick(); chk_out("sw.hold2", 8'h10, 1, 3'd4, 0);
        in_valid = 1; in_sel = 3'd1;
        tick(); chk_out("sw.xfer", 8'h02, 1, 3'd1, 0);
        in_valid = 0; en = 0;
        tick(); chk_out("sw.off", 8'h00, 0, 3'd0, 0);
        en = 1; mode = 1; dwell = 8'd0;
        tick(); chk_out("sw.rescan", 8'h01, 1, 3'd0, 0);

        // async reset mid-scan
        for (int i = 1; i < 7; i++) begin
            tick();
            chk_out($sformatf("pre_rst[%0d]", i), 8'(1 << i), 1, 3'(i), 0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 0, 3'd0, 0);
        chk("async_rst.in_ready", in_ready, 1'b0);
        #4 rst_n = 1'b1;
        tick(); chk_out("post_rst", 8'h01, 1, 3'd0, 0);

        // randomized phase against the reference model
        en = 0; tick();
        m_st = 0; m_pos = 0; m_left = 0; m_valid = 0; m_wrap = 0;
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 14) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1);
            in_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) dwell = 8'($urandom_range(0, 3));
            #1 chk("rnd.in_ready", in_ready, en & ~mode);
            model_step();
            tick();
            chk_out("rnd", m_valid ? 8'(1 << m_pos) : 8'h00, m_valid,
                    3'(m_pos), m_wrap);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_onehot_seq.md
# decoder_onehot_seq

Parametrised, registered binary-to-one-hot decoder with an enable, a valid/ready input handshake and an autonomous scan mode. In decode mode it registers an accepted SEL_W-bit select into a 2**SEL_W-bit one-hot output. In scan mode it walks a single active bit across all outputs with a programmable dwell time. It is the sequential successor to the team's combinational 3-to-8 decoder and serves as a row/bank/channel selector or a strobe sequencer.

## Interface
Parameters:
- SEL_W, default 3: select width. OUT_W = 2**SEL_W is derived and is not overridable.
- DWELL_W, default 8: width of the dwell-time input.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: block enable. Low forces idle and all-zero output.
- mode, input, 1: 0 = decode, 1 = scan.
- in_valid, input, 1: in_sel is valid.
- in_sel, input, SEL_W: binary select.
- in_ready, output, 1: combinational, equal to en & ~mode & rst_n.
- dwell, input, DWELL_W: scan dwell. Each position is held for dwell+1 cycles.
- out, output, OUT_W: registered one-hot, or all-zero.
- out_valid, output, 1: registered; out holds a decoded or scanned value.
- cur_sel, output, SEL_W: registered binary index of the active out bit.
- wrap, output, 1: registered one-cycle pulse when scan returns to index 0.

## Operation
- States: IDLE, DEC, SCAN. Next state is evaluated every cycle:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DEC.
  - en=1, mode=1 -> SCAN.
- Reset values: state IDLE, out 0, out_valid 0, cur_sel 0, wrap 0, dwell counter 0.
- IDLE:
  - out 0, out_valid 0, cur_sel 0, wrap 0, dwell counter 0.
  - Entered one cycle after en falls, from any state.
- DEC:
  - A transfer occurs when in_valid & in_ready.
  - On transfer: out <= 1 << in_sel, cur_sel <= in_sel, out_valid <= 1.
  - Without a transfer, out, cur_sel and out_valid hold.
  - Back-to-back transfers are accepted every cycle; there is no backpressure in DEC.
- Entry into DEC from IDLE: out stays 0 and out_valid stays 0 until the first transfer.
- Entry into DEC from SCAN: out, cur_sel and out_valid=1 hold the last scanned value until the first transfer.
- SCAN:
  - in_ready = 0; in_valid and in_sel are ignored.
  - On entry from IDLE or DEC: out <= 1, cur_sel <= 0, out_valid <= 1, dwell counter loaded with dwell.
  - Each cycle in SCAN: if the counter is nonzero, decrement it. Otherwise advance cur_sel by 1 modulo OUT_W, set out <= 1 << next cur_sel, and reload the counter from the current dwell.
  - dwell is sampled only at load/reload. Changes take effect at the next position.
  - On advance from OUT_W-1 to 0: wrap <= 1 for exactly one cycle, aligned with out = 1. Otherwise wrap <= 0.
  - The entry load to index 0 does not pulse wrap.
- out is always either exactly one-hot or all-zero. It is never multi-hot, including across mode switches.
- Reset asserted mid-operation clears all registers immediately (asynchronously) and forces in_ready low. After release, the first rising edge evaluates en/mode normally.
- SEL_W = 1 must work: OUT_W = 2, and scan alternates 01, 10.

## Timing
- DEC latency: a transfer at edge T makes out valid after edge T, i.e. one cycle.
- Scan with dwell = D: each index is held for exactly D+1 cycles.
- Full scan period: OUT_W*(D+1) cycles.
- D = 0 advances every cycle; wrap then pulses once every OUT_W cycles.
- Mode/enable changes sampled at edge T take effect in the outputs after edge T.
- No combinational path from inputs to out, out_valid, cur_sel or wrap. in_ready is the only combinational output.

## Test plan
- Reset/decode: SEL_W=3. Reset, then en=1, mode=0, in_valid=1, in_sel=5 for one cycle. Required: out=0x20, cur_sel=5, out_valid=1 one cycle later, holding after in_valid drops.
- Back-to-back decode: in_sel = 0,7,3 on consecutive cycles with in_valid=1. Required: out=0x01, 0x80, 0x08 on successive cycles. in_valid=0 with in_sel=2 must leave out unchanged.
- Scan D=0: en=1, mode=1, dwell=0. Required:
  - out sequence 0x01, 0x02, …, 0x80, 0x01.
  - wrap high only in the cycle out returns to 0x01 (the 9th output cycle).
  - in_ready=0 throughout.
- Scan D=2 with dwell change: each value is held 3 cycles. dwell changes to 0 mid-position; the current position still completes 3 cycles and subsequent positions last 1 cycle.
- Mode/enable switching:
  - Scan reaches 0x10, then mode=0 with no in_valid: out holds 0x10 and out_valid=1.
  - Transfer in_sel=1: out=0x02.
  - en=0: out=0 and out_valid=0 next cycle.
  - Return to SCAN restarts at 0x01 without a wrap pulse.
- Async reset mid-scan: assert rst_n low between edges while out=0x40. Required: out, out_valid, cur_sel and wrap are 0 immediately and in_ready=0. After release with en=1, mode=1, scan restarts at 0x01.
